// File: rtl/button_conditioner.sv
// Purpose : five-button front end; two-flop sync, per-bit debounce, press pulses,
//           up/down auto-repeat and a single long-press pulse on mid.
// Latency : level/press follow a clean raw step by DEBOUNCE_CYCLES+2 clk edges.
//           No backpressure: every output is a free-running level or single-cycle pulse.
//
// Ports:
//   clk      system clock
//   rst      asynchronous reset, active-high
//   btn_raw  raw buttons {down, up, left, right, mid}, asynchronous to clk
//   level    debounced levels, same bit order
//   press    one-cycle pulse per debounced press; up/down also pulse on auto-repeat
//   long_mid one-cycle pulse once mid has been held LONG_CYCLES cycles
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000,
    parameter int unsigned LONG_CYCLES     = 100000000,
    parameter int unsigned CNT_W           = 28
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] btn_raw,
    output logic [4:0] level,
    output logic [4:0] press,
    output logic       long_mid
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] LG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {REP_IDLE, REP_DELAY, REP_REPEAT} rep_state_t;
    typedef enum logic [1:0] {LNG_IDLE, LNG_COUNT, LNG_DONE} lng_state_t;

    logic [4:0] s1;
    logic [4:0] s2;
    logic [4:0] db_done;   // debounce terminal count reached this edge: level toggles
    logic [4:0] rise;
    logic [4:0] fall;
    logic [1:0] rep_fire;  // {down, up} auto-repeat pulse due this edge

    // Two-flop synchronizer for all five buttons.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
        end
    end

    // Per-bit debounce: count consecutive cycles of disagreement between the
    // synchronized input and the accepted level; any agreement restarts the count.
    for (genvar i = 0; i < 5; i++) begin : g_db
        logic [CNT_W-1:0] cnt;
        logic             lvl;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= '0;
                lvl <= 1'b0;
            end else if (s2[i] == lvl) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                cnt <= '0;
                lvl <= ~lvl;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end

        assign level[i]   = lvl;
        assign db_done[i] = (s2[i] != lvl) && (cnt == DB_LAST);
    end

    assign rise = db_done & ~level;
    assign fall = db_done & level;

    // Auto-repeat for up (bit 3) and down (bit 4). The FSM is entered on the
    // same edge that raises level, so the delay is measured from the press pulse.
    for (genvar k = 0; k < 2; k++) begin : g_rep
        localparam int B = 3 + k;
        rep_state_t       state;
        logic [CNT_W-1:0] rcnt;

        // A release on the same edge as a due repeat wins: no pulse.
        assign rep_fire[k] = !fall[B] &&
                             (((state == REP_DELAY)  && (rcnt == RD_LAST)) ||
                              ((state == REP_REPEAT) && (rcnt == RP_LAST)));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state <= REP_IDLE;
                rcnt  <= '0;
            end else if (fall[B]) begin
                state <= REP_IDLE;
                rcnt  <= '0;
            end else begin
                case (state)
                    REP_IDLE: begin
                        if (rise[B]) begin
                            state <= REP_DELAY;
                            rcnt  <= '0;
                        end
                    end
                    REP_DELAY: begin
                        if (rcnt == RD_LAST) begin
                            state <= REP_REPEAT;
                            rcnt  <= '0;
                        end else begin
                            rcnt <= rcnt + CNT_ONE;
                        end
                    end
                    REP_REPEAT: begin
                        if (rcnt == RP_LAST) begin
                            rcnt <= '0;
                        end else begin
                            rcnt <= rcnt + CNT_ONE;
                        end
                    end
                    default: begin
                        state <= REP_IDLE;
                        rcnt  <= '0;
                    end
                endcase
            end
        end
    end

    // Press pulses coincide with the cycle in which level first reads high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            press <= '0;
        end else begin
            press <= rise | {rep_fire, 3'b000};
        end
    end

    // Long press on mid: fires once per hold, re-armed only by a release.
    lng_state_t       lng_state;
    logic [CNT_W-1:0] lcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lng_state <= LNG_IDLE;
            lcnt      <= '0;
            long_mid  <= 1'b0;
        end else begin
            long_mid <= 1'b0;
            if (fall[0]) begin
                lng_state <= LNG_IDLE;
                lcnt      <= '0;
            end else begin
                case (lng_state)
                    LNG_IDLE: begin
                        if (rise[0]) begin
                            lng_state <= LNG_COUNT;
                            lcnt      <= '0;
                        end
                    end
                    LNG_COUNT: begin
                        if (lcnt == LG_LAST) begin
                            long_mid  <= 1'b1;
                            lng_state <= LNG_DONE;
                            lcnt      <= '0;
                        end else begin
                            lcnt <= lcnt + CNT_ONE;
                        end
                    end
                    LNG_DONE: begin
                        lng_state <= LNG_DONE;
                    end
                    default: begin
                        lng_state <= LNG_IDLE;
                        lcnt      <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
`timescale 1ns/1ps
module tb_button_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] btn_raw;
    logic [4:0] level;
    logic [4:0] press;
    logic       long_mid;

    button_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3),
        .LONG_CYCLES    (20),
        .CNT_W          (28)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_raw),
        .level   (level),
        .press   (press),
        .long_mid(long_mid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [4:0] p;
        logic       lm;
    } ev_t;

    ev_t exp_q[$];
    int  n_chk  = 0;
    int  n_pass = 0;

    // Raw step driven at a negedge => level rises 6 sampled cycles later (rel 0).
    // Held 'hold' cycles => level falls at rel 'hold', suppressing any pulse there.
    function automatic bit rep_sched(int rel, int hold);
        return (rel >= 0) && (rel < hold) &&
               ((rel == 0) || ((rel >= 10) && ((rel - 10) % 3 == 0)));
    endfunction

    task automatic test_reset();
        int r;
        n_chk++;
        if (level !== 5'd0 || press !== 5'd0 || long_mid !== 1'b0)
            $display("FAIL reset_state: level=%b press=%b long_mid=%b, need all 0", level, press, long_mid);
        else n_pass++;
        btn_raw = 5'b11111;
        rst     = 1'b0;
        r       = cyc;
        repeat (5) @(negedge clk);
        n_chk++;
        if (level !== 5'd0) $display("FAIL reset_rel_early: level=%b at edge 5, need 00000", level);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (cyc !== r + 6 || level !== 5'b11111 || press !== 5'b11111)
            $display("FAIL reset_rel_rise: level=%b press=%b at edge %0d, need 11111/11111 at edge 6", level, press, cyc - r);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (press !== 5'd0 || level !== 5'b11111)
            $display("FAIL reset_rel_pulse_width: press=%b level=%b, need 00000/11111", press, level);
        else n_pass++;
        // Asynchronous assertion in the middle of the high phase.
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if (level !== 5'd0 || press !== 5'd0 || long_mid !== 1'b0)
            $display("FAIL reset_async: level=%b press=%b long_mid=%b, need all 0", level, press, long_mid);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        r   = cyc;
        repeat (5) @(negedge clk);
        n_chk++;
        if (level !== 5'd0) $display("FAIL reset_held_early: level=%b, need 00000", level);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (level !== 5'b11111 || press !== 5'b11111)
            $display("FAIL reset_held_rise: level=%b press=%b, need 11111/11111", level, press);
        else n_pass++;
        btn_raw = 5'd0;
        rst     = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_bounce();
        int  t0;
        ev_t e;
        int  seq[6] = '{1, 1, 1, 0, 1, 1};
        for (int k = 0; k < 20; k++) begin
            if (k > 0) begin
                if (press !== 5'd0 || long_mid !== 1'b0) begin
                    n_chk++;
                    $display("FAIL bounce_glitch: press=%b long_mid=%b at cycle %0d, need no pulse", press, long_mid, cyc);
                end
            end
            btn_raw[1] = (k < 6) ? seq[k][0] : 1'b0;
            @(negedge clk);
        end
        n_chk++;
        if (level[1] !== 1'b0) $display("FAIL bounce_level: level[1]=%b, need 0", level[1]);
        else n_pass++;
        t0 = cyc;
        btn_raw[1] = 1'b1;
        exp_q.push_back('{t0 + 6, 5'b00010, 1'b0});
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (press !== 5'd0 || long_mid !== 1'b0) begin
                n_chk++;
                if (exp_q.size() == 0)
                    $display("FAIL bounce_evt: unexpected press=%b long_mid=%b at cycle %0d", press, long_mid, cyc);
                else begin
                    e = exp_q.pop_front();
                    if (cyc !== e.cyc || press !== e.p || long_mid !== e.lm)
                        $display("FAIL bounce_evt: got press=%b long_mid=%b at cycle %0d, need press=%b long_mid=%b at cycle %0d",
                                 press, long_mid, cyc, e.p, e.lm, e.cyc);
                    else n_pass++;
                end
            end
            if (cyc == t0 + 6) btn_raw[1] = 1'b0;
        end
        n_chk++;
        if (exp_q.size() != 0) $display("FAIL bounce_missing: %0d events not seen, next due cycle %0d", exp_q.size(), exp_q[0].cyc);
        else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_repeat();
        int  t0;
        ev_t e;
        t0 = cyc;
        btn_raw[3] = 1'b1;
        for (int rel = 0; rel < 50; rel++)
            if (rep_sched(rel, 40)) exp_q.push_back('{t0 + 6 + rel, 5'b01000, 1'b0});
        for (int k = 0; k < 56; k++) begin
            @(negedge clk);
            if (press !== 5'd0 || long_mid !== 1'b0) begin
                n_chk++;
                if (exp_q.size() == 0)
                    $display("FAIL repeat_evt: unexpected press=%b long_mid=%b at cycle %0d", press, long_mid, cyc);
                else begin
                    e = exp_q.pop_front();
                    if (cyc !== e.cyc || press !== e.p || long_mid !== e.lm)
                        $display("FAIL repeat_evt: got press=%b long_mid=%b at cycle %0d, need press=%b long_mid=%b at cycle %0d",
                                 press, long_mid, cyc, e.p, e.lm, e.cyc);
                    else n_pass++;
                end
            end
            if (cyc == t0 + 45) begin
                n_chk++;
                if (level[3] !== 1'b1) $display("FAIL repeat_level_held: level[3]=%b, need 1", level[3]);
                else n_pass++;
            end
            if (cyc == t0 + 46) begin
                n_chk++;
                if (level[3] !== 1'b0) $display("FAIL repeat_level_fall: level[3]=%b, need 0", level[3]);
                else n_pass++;
            end
            if (cyc == t0 + 40) btn_raw[3] = 1'b0;
        end
        n_chk++;
        if (exp_q.size() != 0) $display("FAIL repeat_missing: %0d events not seen, next due cycle %0d", exp_q.size(), exp_q[0].cyc);
        else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_long_press();
        int  t0;
        ev_t e;
        for (int pass = 0; pass < 2; pass++) begin
            t0 = cyc;
            btn_raw[0] = 1'b1;
            exp_q.push_back('{t0 + 6, 5'b00001, 1'b0});
            if (pass == 0) exp_q.push_back('{t0 + 26, 5'b00000, 1'b1});
            for (int k = 0; k < 50; k++) begin
                @(negedge clk);
                if (press !== 5'd0 || long_mid !== 1'b0) begin
                    n_chk++;
                    if (exp_q.size() == 0)
                        $display("FAIL long_evt: unexpected press=%b long_mid=%b at cycle %0d", press, long_mid, cyc);
                    else begin
                        e = exp_q.pop_front();
                        if (cyc !== e.cyc || press !== e.p || long_mid !== e.lm)
                            $display("FAIL long_evt: got press=%b long_mid=%b at cycle %0d, need press=%b long_mid=%b at cycle %0d",
                                     press, long_mid, cyc, e.p, e.lm, e.cyc);
                        else n_pass++;
                    end
                end
                if (cyc == t0 + ((pass == 0) ? 30 : 15)) btn_raw[0] = 1'b0;
            end
            n_chk++;
            if (exp_q.size() != 0) $display("FAIL long_missing: %0d events not seen, next due cycle %0d", exp_q.size(), exp_q[0].cyc);
            else n_pass++;
            exp_q.delete();
        end
    endtask

    task automatic test_concurrent();
        int         t0;
        ev_t        e;
        logic [4:0] p;
        t0 = cyc;
        btn_raw[4:3] = 2'b11;
        for (int rel = 0; rel < 60; rel++) begin
            p = {rep_sched(rel, 35), rep_sched(rel, 20), 3'b000};
            if (p != 5'd0) exp_q.push_back('{t0 + 6 + rel, p, 1'b0});
        end
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (press !== 5'd0 || long_mid !== 1'b0) begin
                n_chk++;
                if (exp_q.size() == 0)
                    $display("FAIL concur_evt: unexpected press=%b long_mid=%b at cycle %0d", press, long_mid, cyc);
                else begin
                    e = exp_q.pop_front();
                    if (cyc !== e.cyc || press !== e.p || long_mid !== e.lm)
                        $display("FAIL concur_evt: got press=%b long_mid=%b at cycle %0d, need press=%b long_mid=%b at cycle %0d",
                                 press, long_mid, cyc, e.p, e.lm, e.cyc);
                    else n_pass++;
                end
            end
            if (cyc == t0 + 20) btn_raw[3] = 1'b0;
            if (cyc == t0 + 35) btn_raw[4] = 1'b0;
        end
        n_chk++;
        if (exp_q.size() != 0) $display("FAIL concur_missing: %0d events not seen, next due cycle %0d", exp_q.size(), exp_q[0].cyc);
        else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_reset_in_repeat();
        int  t0;
        int  r;
        ev_t e;
        t0 = cyc;
        btn_raw[3] = 1'b1;
        for (int rel = 0; rel < 15; rel++)
            if (rep_sched(rel, 15)) exp_q.push_back('{t0 + 6 + rel, 5'b01000, 1'b0});
        for (int k = 0; k < 63; k++) begin
            @(negedge clk);
            if (press !== 5'd0 || long_mid !== 1'b0) begin
                n_chk++;
                if (exp_q.size() == 0)
                    $display("FAIL rstrep_evt: unexpected press=%b long_mid=%b at cycle %0d", press, long_mid, cyc);
                else begin
                    e = exp_q.pop_front();
                    if (cyc !== e.cyc || press !== e.p || long_mid !== e.lm)
                        $display("FAIL rstrep_evt: got press=%b long_mid=%b at cycle %0d, need press=%b long_mid=%b at cycle %0d",
                                 press, long_mid, cyc, e.p, e.lm, e.cyc);
                    else n_pass++;
                end
            end
            if (cyc == t0 + 21) rst = 1'b1;
            if (cyc == t0 + 22) begin
                n_chk++;
                if (level !== 5'd0) $display("FAIL rstrep_level: level=%b during reset, need 00000", level);
                else n_pass++;
            end
            if (cyc == t0 + 23) begin
                rst = 1'b0;
                r   = cyc;
                for (int rel = 0; rel < 40; rel++)
                    if (rep_sched(rel, 20)) exp_q.push_back('{r + 6 + rel, 5'b01000, 1'b0});
            end
            if (cyc == t0 + 43) btn_raw[3] = 1'b0;
        end
        n_chk++;
        if (exp_q.size() != 0) $display("FAIL rstrep_missing: %0d events not seen, next due cycle %0d", exp_q.size(), exp_q[0].cyc);
        else n_pass++;
        exp_q.delete();
    endtask

    initial begin
        rst     = 1'b1;
        btn_raw = 5'd0;
        repeat (3) @(negedge clk);
        test_reset();
        test_bounce();
        test_repeat();
        test_long_press();
        test_concurrent();
        test_reset_in_repeat();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
